iecdrv_fastser_bridge: RTL



---
 rtl/iecdrv_fastser_bridge.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/iecdrv_fastser_bridge.sv
// iecdrv_fastser_bridge
// Bridges the drive's 8520 serial port (SP/CNT) onto the IEC bus SRQ/DATA
// lines for fast-serial (burst) transfers.
//   RX: bus SRQ/DATA -> 2-flop sync -> ce-based deglitch -> cia_cnt_in/cia_sp_in
//   TX: cia_cnt_out/cia_sp_out -> registered -> iec_srq_out/iec_data_out
// A 3-bit bit counter reports byte boundaries; stalled receive bytes are
// abandoned after TIMEOUT ce ticks. Direction changes pass through a
// turnaround state with both bus lines released for TURN_LEN ce ticks.
// Ports:
//   clk, reset (async, active-high), ce (phi2 strobe), dir_out (1 = transmit)
//   cia_sp_out, cia_cnt_out -> CIA outputs;  cia_sp_in, cia_cnt_in -> CIA inputs
//   iec_srq_in, iec_data_in -> async bus levels; iec_srq_out, iec_data_out
//   (1 = released); rx_byte, tx_byte, rx_err pulses; busy level
//
// state      | meaning
// ST_RX      | drive receives, bus lines mirrored into the CIA
// ST_TURN_TX | switching to transmit, everything released
// ST_TX      | drive transmits, CIA outputs drive the bus
// ST_TURN_RX | switching to receive, everything released
module iecdrv_fastser_bridge #(
   parameter int FILTER_LEN = 3,
   parameter int TIMEOUT    = 255,
   parameter int TURN_LEN   = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic ce,
   input  logic dir_out,
   input  logic cia_sp_out,
   input  logic cia_cnt_out,
   output logic cia_sp_in,
   output logic cia_cnt_in,
   input  logic iec_srq_in,
   input  logic iec_data_in,
   output logic iec_srq_out,
   output logic iec_data_out,
   output logic rx_byte,
   output logic tx_byte,
   output logic rx_err,
   output logic busy
);

   typedef enum logic [1:0] {ST_RX, ST_TURN_TX, ST_TX, ST_TURN_RX} state_t;

   localparam logic [3:0]  FL_M1 = 4'(FILTER_LEN - 1);
   localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);
   localparam logic [7:0]  TL_M1 = 8'(TURN_LEN - 1);

   logic       r_srq_s1, r_srq_s2, r_data_s1, r_data_s2;
   logic [3:0] r_srq_fcnt, r_data_fcnt;
   logic       r_srq_filt, r_data_filt, r_srq_filt_d;

   state_t      r_state;
   logic [2:0]  r_bitcnt;
   logic [15:0] r_timer;
   logic [7:0]  r_turn;
   logic        r_cnt_out_d;
   logic        r_cia_sp_in, r_cia_cnt_in, r_iec_srq_out, r_iec_data_out;
   logic        r_rx_byte, r_tx_byte, r_rx_err, r_busy;

   state_t     w_state_nxt;
   logic [2:0] w_bitcnt_nxt;
   logic       w_rx_wrap, w_tx_wrap, w_rx_to;
   logic       w_srq_rise, w_cnt_rise, w_timeout, w_turn_done;

   // Synchronisers and deglitch filters; idle bus level is released (1).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_srq_s1     <= 1'b1;
         r_srq_s2     <= 1'b1;
         r_data_s1    <= 1'b1;
         r_data_s2    <= 1'b1;
         r_srq_fcnt   <= '0;
         r_data_fcnt  <= '0;
         r_srq_filt   <= 1'b1;
         r_data_filt  <= 1'b1;
         r_srq_filt_d <= 1'b1;
      end else begin
         r_srq_s1     <= iec_srq_in;
         r_srq_s2     <= r_srq_s1;
         r_data_s1    <= iec_data_in;
         r_data_s2    <= r_data_s1;
         r_srq_filt_d <= r_srq_filt;
         if (ce) begin
            if (r_srq_s2 == r_srq_filt) begin
               r_srq_fcnt <= '0;
            end else if (r_srq_fcnt == FL_M1) begin
               r_srq_filt <= r_srq_s2;
               r_srq_fcnt <= '0;
            end else begin
               r_srq_fcnt <= r_srq_fcnt + 4'd1;
            end
            if (r_data_s2 == r_data_filt) begin
               r_data_fcnt <= '0;
            end else if (r_data_fcnt == FL_M1) begin
               r_data_filt <= r_data_s2;
               r_data_fcnt <= '0;
            end else begin
               r_data_fcnt <= r_data_fcnt + 4'd1;
            end
         end
      end
   end

   assign w_srq_rise  = r_srq_filt & ~r_srq_filt_d;
   assign w_cnt_rise  = cia_cnt_out & ~r_cnt_out_d;
   assign w_timeout   = ce && (r_timer == TO_M1);
   assign w_turn_done = ce && (r_turn == TL_M1);

   // Next state and bit count. Priority: direction change, then edge, then
   // timeout -- so a wrap or timeout coinciding with a turnaround is dropped.
   always_comb begin
      w_state_nxt  = r_state;
      w_bitcnt_nxt = r_bitcnt;
      w_rx_wrap    = 1'b0;
      w_tx_wrap    = 1'b0;
      w_rx_to      = 1'b0;
      case (r_state)
         ST_RX: begin
            if (dir_out) begin
               w_state_nxt  = ST_TURN_TX;
               w_bitcnt_nxt = '0;
            end else if (w_srq_rise) begin
               w_bitcnt_nxt = r_bitcnt + 3'd1;
               w_rx_wrap    = (r_bitcnt == 3'd7);
            end else if ((r_bitcnt != 3'd0) && w_timeout) begin
               w_bitcnt_nxt = '0;
               w_rx_to      = 1'b1;
            end
         end
         ST_TURN_TX: begin
            w_bitcnt_nxt = '0;
            if (!dir_out)         w_state_nxt = ST_TURN_RX;
            else if (w_turn_done) w_state_nxt = ST_TX;
         end
         ST_TX: begin
            if (!dir_out) begin
               w_state_nxt  = ST_TURN_RX;
               w_bitcnt_nxt = '0;
            end else if (w_cnt_rise) begin
               w_bitcnt_nxt = r_bitcnt + 3'd1;
               w_tx_wrap    = (r_bitcnt == 3'd7);
            end
         end
         ST_TURN_RX: begin
            w_bitcnt_nxt = '0;
            if (dir_out)          w_state_nxt = ST_TURN_TX;
            else if (w_turn_done) w_state_nxt = ST_RX;
         end
         default: begin
            w_state_nxt  = ST_RX;
            w_bitcnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_RX;
         r_bitcnt       <= '0;
         r_timer        <= '0;
         r_turn         <= '0;
         r_cnt_out_d    <= 1'b1;
         r_cia_sp_in    <= 1'b1;
         r_cia_cnt_in   <= 1'b1;
         r_iec_srq_out  <= 1'b1;
         r_iec_data_out <= 1'b1;
         r_rx_byte      <= 1'b0;
         r_tx_byte      <= 1'b0;
         r_rx_err       <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bitcnt    <= w_bitcnt_nxt;
         r_cnt_out_d <= cia_cnt_out;

         // Timer only runs mid-byte in RX; any edge, timeout or exit restarts it.
         if ((r_state != ST_RX) || (w_state_nxt != ST_RX) || w_srq_rise ||
             (r_bitcnt == 3'd0) || w_rx_to)
            r_timer <= '0;
         else if (ce)
            r_timer <= r_timer + 16'd1;

         // Any state change restarts the turnaround count, including a revert.
         if (w_state_nxt != r_state)
            r_turn <= '0;
         else if (((r_state == ST_TURN_TX) || (r_state == ST_TURN_RX)) && ce)
            r_turn <= r_turn + 8'd1;

         // Outputs follow the state being entered so turnaround releases at once.
         r_cia_cnt_in   <= (w_state_nxt == ST_RX) ? r_srq_filt  : 1'b1;
         r_cia_sp_in    <= (w_state_nxt == ST_RX) ? r_data_filt : 1'b1;
         r_iec_srq_out  <= (w_state_nxt == ST_TX) ? cia_cnt_out : 1'b1;
         r_iec_data_out <= (w_state_nxt == ST_TX) ? cia_sp_out  : 1'b1;
         r_rx_byte      <= w_rx_wrap;
         r_tx_byte      <= w_tx_wrap;
         r_rx_err       <= w_rx_to;
         r_busy         <= (w_bitcnt_nxt != 3'd0) ||
                           (w_state_nxt == ST_TURN_TX) || (w_state_nxt == ST_TURN_RX);
      end
   end

   assign cia_sp_in    = r_cia_sp_in;
   assign cia_cnt_in   = r_cia_cnt_in;
   assign iec_srq_out  = r_iec_srq_out;
   assign iec_data_out = r_iec_data_out;
   assign rx_byte      = r_rx_byte;
   assign tx_byte      = r_tx_byte;
   assign rx_err       = r_rx_err;
   assign busy         = r_busy;

endmodule
